// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit: fetch then per-opcode execute over T0..T7
module control_sequencer #(
    parameter logic [4:0] ALU_ADD         = 5'b00011,
    parameter bit         HALT_ON_UNKNOWN = 1'b0
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR_Data,
    input  logic        CON_out,
    output logic        PC_in,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        HI_in,
    output logic        LO_in,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic        OutPort_in,
    output logic        IncPC,
    output logic        PC_out,
    output logic        Zhigh_out,
    output logic        Zlow_out,
    output logic        HI_out,
    output logic        LO_out,
    output logic        MDR_out,
    output logic        InPort_out,
    output logic        C_out,
    output logic        Read,
    output logic        Write,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CON_in,
    output logic [4:0]  alu_instruction_bits,
    output logic        Run
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_ADDI = 5'b01100, OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
    localparam logic [4:0] OP_IN   = 5'b10110, OP_OUT  = 5'b10111, OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001, OP_NOP  = 5'b11010, OP_HALT = 5'b11011;

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  w_op;
    logic [26:0] w_unused_ir;
    logic        w_rtype, w_imm, w_addr, w_br, w_halt, w_known;
    logic [4:0]  w_imm_alu;

    assign w_op        = IR_Data[31:27];
    assign w_unused_ir = IR_Data[26:0];
    assign w_rtype     = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
    assign w_imm       = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
    // ldi, ld and st share the base+offset address computation in T3..T4
    assign w_addr      = (w_op == OP_LDI) || (w_op == OP_LD) || (w_op == OP_ST);
    assign w_br        = (w_op == OP_BR);
    assign w_known     = w_rtype || w_imm || w_addr || w_br || (w_op == OP_JR) || (w_op == OP_IN)
                      || (w_op == OP_OUT) || (w_op == OP_MFHI) || (w_op == OP_MFLO)
                      || (w_op == OP_NOP) || (w_op == OP_HALT);
    assign w_halt      = (w_op == OP_HALT) || (HALT_ON_UNKNOWN && !w_known);
    assign w_imm_alu   = (w_op == OP_ADDI) ? 5'b00011 : (w_op == OP_ANDI) ? 5'b00101 : 5'b00110;

    // state register; clr wins over everything, including HALT
    always_ff @(posedge clk) begin
        if (clr) r_state <= S_RESET;
        else     r_state <= w_next;
    end

    // next-state and control decode from state and opcode
    always_comb begin
        w_next = r_state;
        {PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC} = '0;
        {PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out} = '0;
        {Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in} = '0;
        alu_instruction_bits = 5'b00000;
        Run = (r_state != S_RESET) && (r_state != S_HALT);
        case (r_state)
            S_RESET: w_next = S_T0;
            S_T0: begin PC_out = 1'b1; MAR_in = 1'b1; IncPC = 1'b1; w_next = S_T1; end
            S_T1: begin Read = 1'b1; MDR_in = 1'b1; w_next = S_T2; end
            S_T2: begin MDR_out = 1'b1; IR_in = 1'b1; w_next = S_T3; end
            S_T3: begin
                w_next = S_T0;
                if (w_rtype || w_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Y_in = 1'b1; w_next = S_T4;
                end else if (w_addr) begin
                    Grb = 1'b1; BAout = 1'b1; Y_in = 1'b1; w_next = S_T4;
                end else if (w_br) begin
                    Gra = 1'b1; Rout = 1'b1; CON_in = 1'b1; w_next = S_T4;
                end else if (w_op == OP_JR) begin
                    Gra = 1'b1; Rout = 1'b1; PC_in = 1'b1;
                end else if (w_op == OP_IN) begin
                    InPort_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_op == OP_OUT) begin
                    Gra = 1'b1; Rout = 1'b1; OutPort_in = 1'b1;
                end else if (w_op == OP_MFHI) begin
                    HI_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_op == OP_MFLO) begin
                    LO_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_halt) begin
                    w_next = S_HALT;
                end
            end
            S_T4: begin
                w_next = S_T5;
                if (w_rtype) begin
                    Grc = 1'b1; Rout = 1'b1; Z_in = 1'b1; alu_instruction_bits = w_op;
                end else if (w_imm) begin
                    C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = w_imm_alu;
                end else if (w_addr) begin
                    C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = ALU_ADD;
                end else if (w_br) begin
                    PC_out = 1'b1; Y_in = 1'b1;
                end else begin
                    w_next = S_T0;
                end
            end
            S_T5: begin
                w_next = S_T0;
                if (w_rtype || w_imm || (w_op == OP_LDI)) begin
                    Zlow_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if ((w_op == OP_LD) || (w_op == OP_ST)) begin
                    Zlow_out = 1'b1; MAR_in = 1'b1; w_next = S_T6;
                end else if (w_br) begin
                    C_out = 1'b1; Z_in = 1'b1; alu_instruction_bits = ALU_ADD; w_next = S_T6;
                end
            end
            S_T6: begin
                w_next = S_T0;
                if (w_op == OP_LD) begin
                    Read = 1'b1; MDR_in = 1'b1; w_next = S_T7;
                end else if (w_op == OP_ST) begin
                    // Read low steers the bus, not memory, into MDR
                    Gra = 1'b1; Rout = 1'b1; MDR_in = 1'b1; w_next = S_T7;
                end else if (w_br) begin
                    Zlow_out = 1'b1; PC_in = CON_out;
                end
            end
            S_T7: begin
                w_next = S_T0;
                if (w_op == OP_LD) begin
                    MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (w_op == OP_ST) begin
                    Write = 1'b1;
                end
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized self-checking bench against a microprogram-table model
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] IR_Data = '0;
    logic        CON_out = 1'b0;
    logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
    logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
    logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in, Run;
    logic [4:0] alu_instruction_bits;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR_Data(IR_Data), .CON_out(CON_out),
        .PC_in(PC_in), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in), .HI_in(HI_in), .LO_in(LO_in),
        .MAR_in(MAR_in), .MDR_in(MDR_in), .OutPort_in(OutPort_in), .IncPC(IncPC),
        .PC_out(PC_out), .Zhigh_out(Zhigh_out), .Zlow_out(Zlow_out), .HI_out(HI_out),
        .LO_out(LO_out), .MDR_out(MDR_out), .InPort_out(InPort_out), .C_out(C_out),
        .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .BAout(BAout), .CON_in(CON_in), .alu_instruction_bits(alu_instruction_bits), .Run(Run)
    );

    // every output folded into one word: {Run, alu[4:0], 27 single-bit controls}
    logic [32:0] w_obs;
    assign w_obs = {Run, alu_instruction_bits, CON_in, BAout, Rout, Rin, Grc, Grb, Gra, Write, Read,
                    C_out, InPort_out, MDR_out, LO_out, HI_out, Zlow_out, Zhigh_out, PC_out,
                    IncPC, OutPort_in, MDR_in, MAR_in, LO_in, HI_in, Z_in, Y_in, IR_in, PC_in};

    localparam logic [32:0] PCI = 33'd1 << 0,  IRI = 33'd1 << 1,  YI = 33'd1 << 2,  ZI = 33'd1 << 3;
    localparam logic [32:0] MARI = 33'd1 << 6, MDRI = 33'd1 << 7, OPI = 33'd1 << 8, INC = 33'd1 << 9;
    localparam logic [32:0] PCO = 33'd1 << 10, ZLO = 33'd1 << 12, HIO = 33'd1 << 13, LOO = 33'd1 << 14;
    localparam logic [32:0] MDRO = 33'd1 << 15, INO = 33'd1 << 16, CO = 33'd1 << 17, RD = 33'd1 << 18;
    localparam logic [32:0] WR = 33'd1 << 19, GA = 33'd1 << 20, GB = 33'd1 << 21, GC = 33'd1 << 22;
    localparam logic [32:0] RIN = 33'd1 << 23, ROUT = 33'd1 << 24, BAO = 33'd1 << 25, CONI = 33'd1 << 26;
    localparam logic [32:0] RUN = 33'd1 << 32;

    function automatic logic [32:0] alu(input logic [4:0] v);
        return {1'b0, v, 27'd0};
    endfunction

    logic [32:0] exp_q[$];
    bit          exp_halt;

    // microprogram for one instruction: fetch words followed by the opcode's execute words
    task automatic plan(input logic [4:0] op, input logic con);
        exp_q = '{RUN | PCO | MARI | INC, RUN | RD | MDRI, RUN | MDRO | IRI};
        exp_halt = 0;
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6: begin
                exp_q.push_back(RUN | GB | ROUT | YI);
                exp_q.push_back(RUN | GC | ROUT | ZI | alu(op));
                exp_q.push_back(RUN | ZLO | GA | RIN);
            end
            5'd12, 5'd13, 5'd14: begin
                exp_q.push_back(RUN | GB | ROUT | YI);
                exp_q.push_back(RUN | CO | ZI | alu(op == 5'd12 ? 5'd3 : op == 5'd13 ? 5'd5 : 5'd6));
                exp_q.push_back(RUN | ZLO | GA | RIN);
            end
            5'd0, 5'd1, 5'd2: begin
                exp_q.push_back(RUN | GB | BAO | YI);
                exp_q.push_back(RUN | CO | ZI | alu(5'd3));
                if (op == 5'd1) exp_q.push_back(RUN | ZLO | GA | RIN);
                else begin
                    exp_q.push_back(RUN | ZLO | MARI);
                    if (op == 5'd0) begin
                        exp_q.push_back(RUN | RD | MDRI);
                        exp_q.push_back(RUN | MDRO | GA | RIN);
                    end else begin
                        exp_q.push_back(RUN | GA | ROUT | MDRI);
                        exp_q.push_back(RUN | WR);
                    end
                end
            end
            5'd19: begin
                exp_q.push_back(RUN | GA | ROUT | CONI);
                exp_q.push_back(RUN | PCO | YI);
                exp_q.push_back(RUN | CO | ZI | alu(5'd3));
                exp_q.push_back(RUN | ZLO | (con ? PCI : 33'd0));
            end
            5'd20: exp_q.push_back(RUN | GA | ROUT | PCI);
            5'd22: exp_q.push_back(RUN | INO | GA | RIN);
            5'd23: exp_q.push_back(RUN | GA | ROUT | OPI);
            5'd24: exp_q.push_back(RUN | HIO | GA | RIN);
            5'd25: exp_q.push_back(RUN | LOO | GA | RIN);
            5'd27: begin exp_q.push_back(RUN); exp_halt = 1; end
            default: exp_q.push_back(RUN);
        endcase
    endtask

    task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // run one instruction from T0; optionally assert clr during step clr_step
    task automatic run_instr(input logic [31:0] ir, input logic con, input int clr_step);
        plan(ir[31:27], con);
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk); #1;
            IR_Data = (k < 3) ? $urandom : ir;
            CON_out = con;
            #1 check_eq($sformatf("op%0d_T%0d", ir[31:27], k), w_obs, exp_q[k]);
            if (k == clr_step) begin
                clr = 1'b1;
                @(posedge clk); #1;
                clr = 1'b0;
                #1 check_eq("clr_reset", w_obs, 33'd0);
                return;
            end
        end
    endtask

    function automatic bit listed(input logic [4:0] op);
        return op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14,
                          5'd19, 5'd20, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26, 5'd27};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ops [17];
        logic [4:0] op;
        ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd13, 5'd14,
                5'd19, 5'd20, 5'd22, 5'd23, 5'd24, 5'd25, 5'd26};
        clr = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        clr = 1'b0;
        #1 check_eq("reset_state", w_obs, 33'd0);

        run_instr(32'h18918000, 1'b0, -1);
        run_instr(32'h00800055, 1'b1, -1);
        run_instr(32'h9A080023, 1'b0, -1);
        run_instr(32'h9A080023, 1'b1, -1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                do op = 5'($urandom); while (listed(op));
            end else begin
                op = ops[$urandom_range(0, 16)];
            end
            run_instr({op, 27'($urandom)}, 1'($urandom), -1);
        end

        run_instr(32'h00800055, 1'b0, 5);
        run_instr({5'd2, 27'($urandom)}, 1'b0, -1);
        run_instr({5'd27, 27'd0}, 1'b0, -1);
        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            CON_out = 1'($urandom);
            IR_Data = $urandom;
            #1 check_eq($sformatf("halt_%0d", i), w_obs, 33'd0);
        end
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        #1 check_eq("halt_clr", w_obs, 33'd0);
        run_instr(32'h18918000, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
